// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the frame capture sequencer: state encoding,
// one-hot LEDR mapping and the state-bit indices read back by HPS software.
package frame_seq_pkg;

  localparam int WORDS_PER_FRAME_DEFAULT = 640 * 480 / 16;
  localparam int LED_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SKIP    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } seq_state_e;

  // Bit positions in oSTATE; the HPS software decodes these.
  localparam int STATE_BIT_IDLE    = 0;
  localparam int STATE_BIT_ARM     = 1;
  localparam int STATE_BIT_SKIP    = 2;
  localparam int STATE_BIT_CAPTURE = 3;
  localparam int STATE_BIT_READ    = 4;
  localparam int STATE_BIT_DONE    = 5;
  localparam int STATE_BIT_ERR     = 6;

  localparam logic [LED_W-1:0] LED_IDLE    = 10'b1 << STATE_BIT_IDLE;
  localparam logic [LED_W-1:0] LED_ARM     = 10'b1 << STATE_BIT_ARM;
  localparam logic [LED_W-1:0] LED_SKIP    = 10'b1 << STATE_BIT_SKIP;
  localparam logic [LED_W-1:0] LED_CAPTURE = 10'b1 << STATE_BIT_CAPTURE;
  localparam logic [LED_W-1:0] LED_READ    = 10'b1 << STATE_BIT_READ;
  localparam logic [LED_W-1:0] LED_DONE    = 10'b1 << STATE_BIT_DONE;
  localparam logic [LED_W-1:0] LED_ERR     = 10'b1 << STATE_BIT_ERR;

  function automatic logic [LED_W-1:0] state_led(input seq_state_e s);
    case (s)
      ST_IDLE:    return LED_IDLE;
      ST_ARM:     return LED_ARM;
      ST_SKIP:    return LED_SKIP;
      ST_CAPTURE: return LED_CAPTURE;
      ST_READ:    return LED_READ;
      ST_DONE:    return LED_DONE;
      ST_ERR:     return LED_ERR;
      default:    return LED_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/frame_capture_sequencer_if.sv
// Signal bundle between the HPS/camera side (master) and the sequencer (slave).
interface frame_capture_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              iHPS_START;
  logic              iFVAL;
  logic              iWR_DVAL;
  logic              iRD_REQ;
  logic              oCAP_START;
  logic              oCAP_END;
  logic              oFIFO_LOAD;
  logic              oRD_STROBE;
  logic              oRD_ACK;
  logic [ADDR_W-1:0] oWORD_ADDR;
  logic [15:0]       oFRAME_CNT;
  logic [9:0]        oSTATE;
  logic              oERR;

  modport master (
    output iHPS_START, iFVAL, iWR_DVAL, iRD_REQ,
    input  oCAP_START, oCAP_END, oFIFO_LOAD, oRD_STROBE, oRD_ACK,
           oWORD_ADDR, oFRAME_CNT, oSTATE, oERR
  );

  modport slave (
    input  iHPS_START, iFVAL, iWR_DVAL, iRD_REQ,
    output oCAP_START, oCAP_END, oFIFO_LOAD, oRD_STROBE, oRD_ACK,
           oWORD_ADDR, oFRAME_CNT, oSTATE, oERR
  );
endinterface

// File: rtl/seq_rd_handshake.sv
// Four-phase read responder: req rising edge -> one-cycle pop strobe, ack the
// cycle after, ack held until req drops, word address advances on ack drop.
// The req history runs even while disabled, so a req already high when the
// responder is enabled is not mistaken for a new request.
module seq_rd_handshake #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              req,
  output logic              strobe,
  output logic              ack,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  logic              req_prev_q, req_prev_d;
  logic              strobe_q, strobe_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_c;

  // Next-state for edge detect, strobe, ack and address.
  always_comb begin
    req_prev_d = req;
    done_c     = en & ~clr & ack_q & ~req;
    strobe_d   = en & ~clr & req & ~req_prev_q;
    ack_d      = en & ~clr & (strobe_q | (ack_q & req));
    addr_d     = addr_q;
    if (clr)         addr_d = '0;
    else if (done_c) addr_d = addr_q + 1'b1;
  end

  // Handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prev_q <= 1'b0;
      strobe_q   <= 1'b0;
      ack_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      req_prev_q <= req_prev_d;
      strobe_q   <= strobe_d;
      ack_q      <= ack_d;
      addr_q     <= addr_d;
    end
  end

  assign strobe = strobe_q;
  assign ack    = ack_q;
  assign done   = done_c;
  assign addr   = addr_q;

endmodule

// File: rtl/frame_capture_sequencer.sv
// Sequences one HPS-requested capture: arm, discard warm-up frames, capture one
// frame into the write FIFO, then serve HPS word reads.
// Optional watchdog: define FRAME_SEQ_TIMEOUT_EN to send SKIP/CAPTURE/READ to
// ERR after TIMEOUT_CYC cycles without progress.
//
// state   | meaning
// IDLE    | waiting for iHPS_START
// ARM     | one cycle: reload FIFO pointers, clear counters
// SKIP    | discarding FRAME_SKIP complete frames
// CAPTURE | capture path enabled, counting written words
// READ    | serving HPS four-phase word reads
// DONE    | all words read, waiting for start to drop
// ERR     | wrong word count (or watchdog), waiting for start to drop
module frame_capture_sequencer
  import frame_seq_pkg::*;
#(
  parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEFAULT,
  parameter int FRAME_SKIP      = 1,
  parameter int ADDR_W          = 16,
  parameter int TIMEOUT_CYC     = 50000000
) (
  input logic iCLK,
  input logic iRST,
  frame_capture_sequencer_if.slave bus
);

  seq_state_e        state_q, state_d;
  logic              fval_prev_q;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d, word_inc;
  logic [15:0]       skip_cnt_q, skip_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              cap_start_q, cap_start_d;
  logic              cap_end_q, cap_end_d;
  logic              fifo_load_q, fifo_load_d;
  logic              err_q, err_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              frame_end, abort, hs_clr, hs_en;
  logic              hs_done;
  logic [ADDR_W-1:0] hs_addr;

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic [31:0]       wd_cnt_q, wd_cnt_d;
  logic              wd_active;
`else
  logic              unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign frame_end = fval_prev_q & ~bus.iFVAL;
  assign hs_en     = (state_q == ST_READ);

  seq_rd_handshake #(.ADDR_W(ADDR_W)) u_rd_hs (
    .clk    (iCLK),
    .rst    (iRST),
    .en     (hs_en),
    .clr    (hs_clr),
    .req    (bus.iRD_REQ),
    .strobe (bus.oRD_STROBE),
    .ack    (bus.oRD_ACK),
    .done   (hs_done),
    .addr   (hs_addr)
  );

  // Next state, counters and the registered output values.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    frame_cnt_d = frame_cnt_q;
    abort       = 1'b0;
    word_inc    = word_cnt_q;
    if (bus.iWR_DVAL && (word_cnt_q != '1)) word_inc = word_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: if (bus.iHPS_START) state_d = ST_ARM;
      ST_ARM: begin
        word_cnt_d = '0;
        skip_cnt_d = '0;
        if (!bus.iHPS_START)    abort   = 1'b1;
        else if (FRAME_SKIP == 0) state_d = ST_CAPTURE;
        else                    state_d = ST_SKIP;
      end
      ST_SKIP: begin
        if (!bus.iHPS_START) abort = 1'b1;
        else if (frame_end) begin
          skip_cnt_d = skip_cnt_q + 1'b1;
          if (skip_cnt_d >= 16'(FRAME_SKIP)) state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!bus.iHPS_START) abort = 1'b1;
        else begin
          // A word strobed in the frame_end cycle is counted before the compare.
          word_cnt_d = word_inc;
          if (frame_end) begin
            if (word_inc == ADDR_W'(WORDS_PER_FRAME)) begin
              state_d     = ST_READ;
              frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
              state_d = ST_ERR;
            end
          end
        end
      end
      ST_READ: begin
        if (!bus.iHPS_START) abort = 1'b1;
        else if (hs_done && (hs_addr == ADDR_W'(WORDS_PER_FRAME - 1))) state_d = ST_DONE;
      end
      ST_DONE, ST_ERR: if (!bus.iHPS_START) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      word_cnt_d = '0;
      skip_cnt_d = '0;
    end

`ifdef FRAME_SEQ_TIMEOUT_EN
    wd_active = (state_q == ST_SKIP) || (state_q == ST_CAPTURE) || (state_q == ST_READ);
    if (wd_active && !abort && (state_d == state_q) && (wd_cnt_q == 32'(TIMEOUT_CYC - 1)))
      state_d = ST_ERR;
    wd_cnt_d = (!wd_active || (state_d != state_q) || hs_done) ? '0 : wd_cnt_q + 1'b1;
`endif

    hs_clr      = abort || (state_q == ST_ARM);
    cap_start_d = (state_d == ST_CAPTURE);
    cap_end_d   = (state_d == ST_READ) || (state_d == ST_DONE) || (state_d == ST_ERR);
    fifo_load_d = (state_d == ST_ARM);
    err_d       = (state_d == ST_ERR);
    led_d       = state_led(state_d);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      fval_prev_q <= 1'b0;
      word_cnt_q  <= '0;
      skip_cnt_q  <= '0;
      frame_cnt_q <= '0;
      cap_start_q <= 1'b0;
      cap_end_q   <= 1'b0;
      fifo_load_q <= 1'b0;
      err_q       <= 1'b0;
      led_q       <= LED_IDLE;
`ifdef FRAME_SEQ_TIMEOUT_EN
      wd_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fval_prev_q <= bus.iFVAL;
      word_cnt_q  <= word_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      cap_start_q <= cap_start_d;
      cap_end_q   <= cap_end_d;
      fifo_load_q <= fifo_load_d;
      err_q       <= err_d;
      led_q       <= led_d;
`ifdef FRAME_SEQ_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
`endif
    end
  end

  assign bus.oCAP_START = cap_start_q;
  assign bus.oCAP_END   = cap_end_q;
  assign bus.oFIFO_LOAD = fifo_load_q;
  assign bus.oWORD_ADDR = hs_addr;
  assign bus.oFRAME_CNT = frame_cnt_q;
  assign bus.oSTATE     = led_q;
  assign bus.oERR       = err_q;

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// Directed bench for frame_capture_sequencer with WORDS_PER_FRAME=4,
// FRAME_SKIP=1, TIMEOUT_CYC=100.
module tb_frame_capture_sequencer;

  logic iCLK;
  logic iRST;
  int   checks = 0;
  int   errors = 0;
  int   load_cnt = 0;
  int   strobe_cnt = 0;

  frame_capture_sequencer_if #(.ADDR_W(16)) bus ();

  frame_capture_sequencer #(
    .WORDS_PER_FRAME (4),
    .FRAME_SKIP      (1),
    .ADDR_W          (16),
    .TIMEOUT_CYC     (100)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Pulse counters and the start/end exclusion, sampled just after each edge.
  always begin
    @(posedge iCLK);
    #1;
    if (bus.oFIFO_LOAD) load_cnt++;
    if (bus.oRD_STROBE) strobe_cnt++;
    checks++;
    if (bus.oCAP_START && bus.oCAP_END) begin
      errors++;
      $display("FAIL cap_excl: start=%0b end=%0b, required not both 1", bus.oCAP_START, bus.oCAP_END);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // One camera frame with n word strobes; optionally the last strobe lands
  // in the cycle where iFVAL falls.
  task automatic send_frame(input int n, input bit coincide);
    bus.iFVAL = 1'b1;
    tick(1);
    for (int i = 0; i < (coincide ? n - 1 : n); i++) begin
      bus.iWR_DVAL = 1'b1;
      tick(1);
      bus.iWR_DVAL = 1'b0;
      tick(1);
    end
    bus.iFVAL    = 1'b0;
    bus.iWR_DVAL = coincide;
    tick(1);
    bus.iWR_DVAL = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    iRST = 1'b1;
    bus.iHPS_START = 1'b0;
    bus.iFVAL      = 1'b0;
    bus.iWR_DVAL   = 1'b0;
    bus.iRD_REQ    = 1'b0;
    tick(3);
    iRST = 1'b0;
    tick(2);
    checks++;
    if (bus.oSTATE !== 10'h001) begin
      errors++; $display("FAIL reset_state: got %h, required 001", bus.oSTATE);
    end
    checks++;
    if ({bus.oCAP_START, bus.oCAP_END, bus.oFIFO_LOAD, bus.oRD_STROBE, bus.oRD_ACK, bus.oERR} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b, required 000000",
        {bus.oCAP_START, bus.oCAP_END, bus.oFIFO_LOAD, bus.oRD_STROBE, bus.oRD_ACK, bus.oERR});
    end
    checks++;
    if ({bus.oWORD_ADDR, bus.oFRAME_CNT} !== 32'h0) begin
      errors++; $display("FAIL reset_counts: addr=%0d frames=%0d, required 0 0", bus.oWORD_ADDR, bus.oFRAME_CNT);
    end
  endtask

  task automatic test_capture;
    bus.iHPS_START = 1'b1;
    tick(1);
    checks++;
    if (bus.oSTATE !== 10'h002 || bus.oFIFO_LOAD !== 1'b1) begin
      errors++; $display("FAIL arm: state=%h load=%0b, required 002 1", bus.oSTATE, bus.oFIFO_LOAD);
    end
    tick(1);
    checks++;
    if (bus.oSTATE !== 10'h004 || bus.oCAP_START !== 1'b0 || bus.oFIFO_LOAD !== 1'b0) begin
      errors++; $display("FAIL skip_entry: state=%h cap_start=%0b load=%0b, required 004 0 0",
        bus.oSTATE, bus.oCAP_START, bus.oFIFO_LOAD);
    end
    send_frame(4, 1'b0);
    checks++;
    if (bus.oSTATE !== 10'h008 || bus.oCAP_START !== 1'b1) begin
      errors++; $display("FAIL capture_entry: state=%h cap_start=%0b, required 008 1", bus.oSTATE, bus.oCAP_START);
    end
    send_frame(4, 1'b0);
    checks++;
    if (bus.oSTATE !== 10'h010 || bus.oCAP_START !== 1'b0 || bus.oCAP_END !== 1'b1) begin
      errors++; $display("FAIL read_entry: state=%h start=%0b end=%0b, required 010 0 1",
        bus.oSTATE, bus.oCAP_START, bus.oCAP_END);
    end
    checks++;
    if (bus.oFRAME_CNT !== 16'd1 || load_cnt != 1 || bus.oWORD_ADDR !== 16'd0) begin
      errors++; $display("FAIL capture_counts: frames=%0d loads=%0d addr=%0d, required 1 1 0",
        bus.oFRAME_CNT, load_cnt, bus.oWORD_ADDR);
    end
  endtask

  task automatic test_read;
    int s0;
    s0 = strobe_cnt;
    for (int k = 0; k < 4; k++) begin
      bus.iRD_REQ = 1'b1;
      tick(1);
      checks++;
      if (bus.oRD_STROBE !== 1'b1 || bus.oRD_ACK !== 1'b0 || bus.oWORD_ADDR !== 16'(k)) begin
        errors++; $display("FAIL rd_strobe[%0d]: strobe=%0b ack=%0b addr=%0d, required 1 0 %0d",
          k, bus.oRD_STROBE, bus.oRD_ACK, bus.oWORD_ADDR, k);
      end
      tick(3);
      checks++;
      if (bus.oRD_STROBE !== 1'b0 || bus.oRD_ACK !== 1'b1) begin
        errors++; $display("FAIL rd_ack_hold[%0d]: strobe=%0b ack=%0b, required 0 1", k, bus.oRD_STROBE, bus.oRD_ACK);
      end
      bus.iRD_REQ = 1'b0;
      tick(1);
      checks++;
      if (bus.oRD_ACK !== 1'b0 || bus.oWORD_ADDR !== 16'(k + 1)) begin
        errors++; $display("FAIL rd_ack_drop[%0d]: ack=%0b addr=%0d, required 0 %0d", k, bus.oRD_ACK, bus.oWORD_ADDR, k + 1);
      end
    end
    checks++;
    if (bus.oSTATE !== 10'h020 || strobe_cnt - s0 != 4 || bus.oCAP_END !== 1'b1) begin
      errors++; $display("FAIL read_done: state=%h strobes=%0d end=%0b, required 020 4 1",
        bus.oSTATE, strobe_cnt - s0, bus.oCAP_END);
    end
    bus.iHPS_START = 1'b0;
    tick(1);
    checks++;
    if (bus.oSTATE !== 10'h001 || bus.oCAP_END !== 1'b0) begin
      errors++; $display("FAIL done_exit: state=%h end=%0b, required 001 0", bus.oSTATE, bus.oCAP_END);
    end
  endtask

  task automatic test_short_frame;
    bus.iHPS_START = 1'b1;
    tick(2);
    send_frame(0, 1'b0);
    send_frame(3, 1'b0);
    checks++;
    if (bus.oSTATE !== 10'h040 || bus.oERR !== 1'b1 || bus.oCAP_END !== 1'b1 || bus.oFRAME_CNT !== 16'd1) begin
      errors++; $display("FAIL short_frame: state=%h err=%0b end=%0b frames=%0d, required 040 1 1 1",
        bus.oSTATE, bus.oERR, bus.oCAP_END, bus.oFRAME_CNT);
    end
    bus.iHPS_START = 1'b0;
    tick(1);
    checks++;
    if (bus.oSTATE !== 10'h001 || bus.oERR !== 1'b0) begin
      errors++; $display("FAIL err_clear: state=%h err=%0b, required 001 0", bus.oSTATE, bus.oERR);
    end
  endtask

  task automatic test_coincident_word;
    int s0;
    bus.iHPS_START = 1'b1;
    tick(2);
    send_frame(0, 1'b0);
    bus.iRD_REQ = 1'b1;
    send_frame(4, 1'b1);
    checks++;
    if (bus.oSTATE !== 10'h010 || bus.oFRAME_CNT !== 16'd2) begin
      errors++; $display("FAIL coincident_word: state=%h frames=%0d, required 010 2", bus.oSTATE, bus.oFRAME_CNT);
    end
    s0 = strobe_cnt;
    tick(3);
    checks++;
    if (strobe_cnt != s0 || bus.oRD_ACK !== 1'b0) begin
      errors++; $display("FAIL req_high_on_entry: strobes=%0d ack=%0b, required 0 0", strobe_cnt - s0, bus.oRD_ACK);
    end
    bus.iRD_REQ = 1'b0;
    tick(1);
    bus.iRD_REQ = 1'b1;
    tick(2);
    checks++;
    if (bus.oRD_ACK !== 1'b1 || strobe_cnt - s0 != 1) begin
      errors++; $display("FAIL req_after_drop: ack=%0b strobes=%0d, required 1 1", bus.oRD_ACK, strobe_cnt - s0);
    end
    bus.iHPS_START = 1'b0;
    tick(1);
    checks++;
    if (bus.oSTATE !== 10'h001 || bus.oRD_ACK !== 1'b0 || bus.oWORD_ADDR !== 16'd0) begin
      errors++; $display("FAIL abort_read: state=%h ack=%0b addr=%0d, required 001 0 0",
        bus.oSTATE, bus.oRD_ACK, bus.oWORD_ADDR);
    end
    bus.iRD_REQ = 1'b0;
    tick(1);
  endtask

  task automatic test_abort_capture;
    int l0;
    bus.iHPS_START = 1'b1;
    tick(2);
    send_frame(0, 1'b0);
    bus.iFVAL = 1'b1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      bus.iWR_DVAL = 1'b1; tick(1); bus.iWR_DVAL = 1'b0; tick(1);
    end
    checks++;
    if (bus.oCAP_START !== 1'b1) begin
      errors++; $display("FAIL mid_capture: cap_start=%0b, required 1", bus.oCAP_START);
    end
    bus.iHPS_START = 1'b0;
    tick(1);
    checks++;
    if (bus.oSTATE !== 10'h001 || bus.oCAP_START !== 1'b0 || bus.oFRAME_CNT !== 16'd2) begin
      errors++; $display("FAIL abort_capture: state=%h cap_start=%0b frames=%0d, required 001 0 2",
        bus.oSTATE, bus.oCAP_START, bus.oFRAME_CNT);
    end
    bus.iFVAL = 1'b0;
    tick(2);
    l0 = load_cnt;
    bus.iHPS_START = 1'b1;
    tick(2);
    checks++;
    if (load_cnt != l0 + 1 || bus.oSTATE !== 10'h004) begin
      errors++; $display("FAIL rerun_load: loads=%0d state=%h, required 1 004", load_cnt - l0, bus.oSTATE);
    end
    send_frame(0, 1'b0);
    send_frame(4, 1'b0);
    checks++;
    if (bus.oSTATE !== 10'h010 || bus.oFRAME_CNT !== 16'd3) begin
      errors++; $display("FAIL rerun_read: state=%h frames=%0d, required 010 3", bus.oSTATE, bus.oFRAME_CNT);
    end
  endtask

  task automatic test_reset_mid_read;
    bus.iRD_REQ = 1'b1;
    tick(2);
    checks++;
    if (bus.oRD_ACK !== 1'b1) begin
      errors++; $display("FAIL pre_reset_ack: ack=%0b, required 1", bus.oRD_ACK);
    end
    #2 iRST = 1'b1;
    #1;
    checks++;
    if (bus.oSTATE !== 10'h001 ||
        {bus.oCAP_START, bus.oCAP_END, bus.oFIFO_LOAD, bus.oRD_STROBE, bus.oRD_ACK, bus.oERR} !== 6'b0 ||
        bus.oWORD_ADDR !== 16'd0 || bus.oFRAME_CNT !== 16'd0) begin
      errors++; $display("FAIL async_reset: state=%h flags=%b addr=%0d frames=%0d, required 001 000000 0 0",
        bus.oSTATE, {bus.oCAP_START, bus.oCAP_END, bus.oFIFO_LOAD, bus.oRD_STROBE, bus.oRD_ACK, bus.oERR},
        bus.oWORD_ADDR, bus.oFRAME_CNT);
    end
    @(negedge iCLK);
    bus.iRD_REQ    = 1'b0;
    bus.iHPS_START = 1'b0;
    iRST           = 1'b0;
    tick(2);
  endtask

  task automatic test_watchdog;
    bus.iHPS_START = 1'b1;
    bus.iFVAL      = 1'b1;
    tick(2);
`ifdef FRAME_SEQ_TIMEOUT_EN
    tick(99);
    checks++;
    if (bus.oSTATE !== 10'h004) begin
      errors++; $display("FAIL wd_before: state=%h, required 004", bus.oSTATE);
    end
    tick(1);
    checks++;
    if (bus.oSTATE !== 10'h040 || bus.oERR !== 1'b1) begin
      errors++; $display("FAIL wd_expire: state=%h err=%0b, required 040 1", bus.oSTATE, bus.oERR);
    end
`else
    tick(1000);
    checks++;
    if (bus.oSTATE !== 10'h004 || bus.oERR !== 1'b0) begin
      errors++; $display("FAIL no_watchdog: state=%h err=%0b, required 004 0", bus.oSTATE, bus.oERR);
    end
`endif
    bus.iHPS_START = 1'b0;
    bus.iFVAL      = 1'b0;
    tick(1);
    checks++;
    if (bus.oSTATE !== 10'h001) begin
      errors++; $display("FAIL wd_exit: state=%h, required 001", bus.oSTATE);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_read();
    test_short_frame();
    test_coincident_word();
    test_abort_capture();
    test_reset_mid_read();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
